design1_wrapper: RTL and testbench
==================================

Name: design1_wrapper

Overview:
Top-level board wrapper for a Zynq-style processing-system (PS) block design with a behavioural PS model inside.
- Models PS power-on and system reset.
- Generates the PL reset under control of a soft-reset register.
- Runs a DDR3 pin power-up sequence, then idles the DDR bus.
- Holds a word-addressed DDR memory model that simulation can preload.
- Exports DDR, MIO and FIXED_IO pins only. Control uses tasks at hierarchy path design_1_i.processing_system7_0.inst.

Parameters:
DDR_RST_CYCLES, 10, ps_clk cycles DDR_reset_n held low after reset release
DDR_CKE_CYCLES, 5, ps_clk cycles DDR_cke held low after DDR_reset_n rises
MEM_WORDS, 1024, 32-bit words in the internal DDR memory model

Ports:
FIXED_IO_ps_clk  inout  1  PS reference clock; the only clock, rising edge
FIXED_IO_ps_porb  inout  1  power-on reset; asynchronous, active-low
FIXED_IO_ps_srstb  inout  1  system reset; asynchronous, active-low; ANDed with porb
DDR_addr  inout  15  DDR address
DDR_ba  inout  3  bank address
DDR_cas_n / DDR_ras_n / DDR_we_n  inout  1 each  command pins
DDR_ck_p / DDR_ck_n  inout  1 each  differential DDR clock
DDR_cke  inout  1  clock enable
DDR_cs_n  inout  1  chip select
DDR_odt  inout  1  on-die termination
DDR_reset_n  inout  1  DDR device reset
DDR_dm  inout  4  data mask
DDR_dq  inout  32  data
DDR_dqs_p / DDR_dqs_n  inout  4 each  strobes
FIXED_IO_ddr_vrn / FIXED_IO_ddr_vrp  inout  1 each  impedance reference
FIXED_IO_mio  inout  54  multiplexed I/O

Behaviour:
- Clocking and reset: one clock and one asynchronous, active-low reset, exactly as decided for this block. The clock is FIXED_IO_ps_clk. The reset is FIXED_IO_ps_porb, and rst_n = porb & srstb.
- Reset assertion is asynchronous. Release takes effect at the next rising ps_clk.
- While rst_n = 0, all of the following hold:
  - DDR_reset_n = 0, DDR_cke = 0, DDR_odt = 0.
  - DDR_cs_n = DDR_ras_n = DDR_cas_n = DDR_we_n = 1.
  - DDR_addr = 0, DDR_ba = 0, DDR_dm = 0.
  - DDR_ck_p = 0, DDR_ck_n = 1.
  - FPGA_RST_CTRL = 4'h0 and FIXED_IO_mio[7] = 0.
- Always high-Z: DDR_dq, DDR_dqs_p/n, ddr_vrn/vrp, and mio[53:0] except bit 7.
- DDR power-up FSM states: RST, CKE_WAIT, IDLE.
  - RST: the state entered on reset. Counts DDR_RST_CYCLES rising edges after release. On the last edge, DDR_reset_n goes to 1 and the FSM moves to CKE_WAIT.
  - CKE_WAIT: counts DDR_CKE_CYCLES edges. On the last edge, DDR_cke goes to 1 and the FSM moves to IDLE.
  - IDLE: terminal state. Command pins stay at NOP (all 1); DDR_ck_p toggles every ps_clk edge, with DDR_ck_n = ~DDR_ck_p.
  - DDR_ck_p holds 0 in RST and CKE_WAIT.
  - Reset asserted in any state returns the FSM to RST immediately and restarts the counts.
  - The FSM is unaffected by FPGA_RST_CTRL.
- PL reset:
  - pl_resetn0 = rst_n & ~FPGA_RST_CTRL[0], driven on FIXED_IO_mio[7].
  - It asserts combinationally, without waiting for a clock.
- Task fpga_soft_reset(input [31:0] v): waits for one rising ps_clk, then sets FPGA_RST_CTRL <= v[3:0]. Bits [31:4] are ignored.
- Task pre_load_mem(input [1:0] mode, input [31:0] addr, input integer n): fills words addr[31:2] through addr[31:2]+n-1 of the memory model.
  - mode 00: $random data.
  - mode 01: zeros.
  - mode 10: incrementing from 0.
  - mode 11: all 1s.
  - Word indices wrap modulo MEM_WORDS. It completes in zero simulation time.
- Task read_mem(input [31:0] addr, output [31:0] d) returns the word at index addr[31:2] mod MEM_WORDS.
- Memory contents are not cleared by any reset. Uninitialised words read X.

Test Plan:
- Hold porb = srstb = 0, then release at a rising edge -> all reset values above. DDR_reset_n rises exactly 10 edges after release; DDR_cke rises 5 edges later; DDR_ck_p toggles from then on.
- After IDLE, fpga_soft_reset(32'h1) -> mio[7] = 0 one edge later. Then fpga_soft_reset(32'h0) -> mio[7] = 1. DDR_cke stays 1 throughout.
- fpga_soft_reset(32'hFFFF_FFF0) -> FPGA_RST_CTRL = 0 and mio[7] stays 1.
- Pull srstb low for 1 ns mid-CKE_WAIT -> DDR_cke = 0, DDR_reset_n = 0 and mio[7] = 0 immediately. After release, the full 10+5 sequence repeats.
- pre_load_mem(2'b10, 32'h0000_0FF8, 4) -> read_mem returns 0 at 0xFF8, 1 at 0xFFC, 2 at 0x000, 3 at 0x004 (wrap).
- pre_load_mem(2'b11, 32'h0, 1), then porb pulse -> read_mem(0) still returns FFFF_FFFF.

Source files
------------

// File: rtl/design1_wrapper.sv
// Board wrapper for a Zynq-style PS block design with a behavioural PS model:
// reset handling, soft PL reset, DDR3 power-up sequencing and a preloadable DDR word memory.

module processing_system7_bfm #(
    parameter int unsigned DDR_RST_CYCLES = 10,
    parameter int unsigned DDR_CKE_CYCLES = 5,
    parameter int unsigned MEM_WORDS      = 1024
) (
    input  logic        ps_clk,
    input  logic        ps_porb,
    input  logic        ps_srstb,
    output logic [14:0] ddr_addr,
    output logic [2:0]  ddr_ba,
    output logic        ddr_cas_n,
    output logic        ddr_ras_n,
    output logic        ddr_we_n,
    output logic        ddr_ck_p,
    output logic        ddr_ck_n,
    output logic        ddr_cke,
    output logic        ddr_cs_n,
    output logic        ddr_odt,
    output logic        ddr_reset_n,
    output logic [3:0]  ddr_dm,
    output logic        pl_resetn0
);
    localparam int unsigned CNT_MAX = (DDR_RST_CYCLES > DDR_CKE_CYCLES) ? DDR_RST_CYCLES : DDR_CKE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_RST,
        ST_CKE_WAIT,
        ST_IDLE
    } state_t;

    logic             clk;
    logic             rst_n;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_n_q, reset_n_d;
    logic             cke_q, cke_d;
    logic             ck_p_q, ck_p_d;
    logic [3:0]       fpga_rst_ctrl;
    logic [31:0]      mem [MEM_WORDS];

    // Handshake from fpga_soft_reset into the clocked control register
    logic             soft_pend;
    logic [3:0]       soft_val;

    assign clk   = ps_clk;
    assign rst_n = ps_porb & ps_srstb;

    // DDR power-up sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            cnt_q     <= '0;
            reset_n_q <= 1'b0;
            cke_q     <= 1'b0;
            ck_p_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reset_n_q <= reset_n_d;
            cke_q     <= cke_d;
            ck_p_q    <= ck_p_d;
        end
    end

    // Next-state: hold DDR reset, then hold CKE low, then free-run the DDR clock
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reset_n_d = reset_n_q;
        cke_d     = cke_q;
        ck_p_d    = 1'b0;
        case (state_q)
            ST_RST: begin
                if (cnt_q == CNT_W'(DDR_RST_CYCLES - 1)) begin
                    cnt_d     = '0;
                    reset_n_d = 1'b1;
                    state_d   = ST_CKE_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CKE_WAIT: begin
                if (cnt_q == CNT_W'(DDR_CKE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    cke_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                ck_p_d = ~ck_p_q;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpga_rst_ctrl <= 4'h0;
        end else if (soft_pend) begin
            fpga_rst_ctrl <= soft_val;
        end
    end

    assign pl_resetn0  = rst_n & ~fpga_rst_ctrl[0];
    assign ddr_reset_n = reset_n_q;
    assign ddr_cke     = cke_q;
    assign ddr_ck_p    = ck_p_q;
    assign ddr_ck_n    = ~ck_p_q;
    assign ddr_odt     = 1'b0;
    assign ddr_cs_n    = 1'b1;
    assign ddr_ras_n   = 1'b1;
    assign ddr_cas_n   = 1'b1;
    assign ddr_we_n    = 1'b1;
    assign ddr_addr    = 15'h0;
    assign ddr_ba      = 3'h0;
    assign ddr_dm      = 4'h0;

    task automatic fpga_soft_reset(input logic [31:0] v);
        soft_val  = 4'(v);
        soft_pend = 1'b1;
        @(posedge clk);
        soft_pend <= 1'b0;
    endtask

    task automatic pre_load_mem(input logic [1:0] mode, input logic [31:0] addr, input integer n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] idx;
            idx = AW'((32'(addr >> 2) + 32'(i)) % MEM_WORDS);
            case (mode)
                2'b00:   mem[idx] = 32'($random);
                2'b01:   mem[idx] = 32'h0;
                2'b10:   mem[idx] = 32'(i);
                default: mem[idx] = 32'hFFFF_FFFF;
            endcase
        end
    endtask

    task automatic read_mem(input logic [31:0] addr, output logic [31:0] d);
        d = mem[AW'(32'(addr >> 2) % MEM_WORDS)];
    endtask
endmodule

module design_1_processing_system7_0_0 #(
    parameter int unsigned DDR_RST_CYCLES = 10,
    parameter int unsigned DDR_CKE_CYCLES = 5,
    parameter int unsigned MEM_WORDS      = 1024
) (
    input  logic        ps_clk,
    input  logic        ps_porb,
    input  logic        ps_srstb,
    output logic [14:0] ddr_addr,
    output logic [2:0]  ddr_ba,
    output logic        ddr_cas_n,
    output logic        ddr_ras_n,
    output logic        ddr_we_n,
    output logic        ddr_ck_p,
    output logic        ddr_ck_n,
    output logic        ddr_cke,
    output logic        ddr_cs_n,
    output logic        ddr_odt,
    output logic        ddr_reset_n,
    output logic [3:0]  ddr_dm,
    output logic        pl_resetn0
);
    processing_system7_bfm #(
        .DDR_RST_CYCLES(DDR_RST_CYCLES),
        .DDR_CKE_CYCLES(DDR_CKE_CYCLES),
        .MEM_WORDS     (MEM_WORDS)
    ) inst (.*);
endmodule

module design_1 #(
    parameter int unsigned DDR_RST_CYCLES = 10,
    parameter int unsigned DDR_CKE_CYCLES = 5,
    parameter int unsigned MEM_WORDS      = 1024
) (
    input  logic        ps_clk,
    input  logic        ps_porb,
    input  logic        ps_srstb,
    output logic [14:0] ddr_addr,
    output logic [2:0]  ddr_ba,
    output logic        ddr_cas_n,
    output logic        ddr_ras_n,
    output logic        ddr_we_n,
    output logic        ddr_ck_p,
    output logic        ddr_ck_n,
    output logic        ddr_cke,
    output logic        ddr_cs_n,
    output logic        ddr_odt,
    output logic        ddr_reset_n,
    output logic [3:0]  ddr_dm,
    output logic        pl_resetn0
);
    design_1_processing_system7_0_0 #(
        .DDR_RST_CYCLES(DDR_RST_CYCLES),
        .DDR_CKE_CYCLES(DDR_CKE_CYCLES),
        .MEM_WORDS     (MEM_WORDS)
    ) processing_system7_0 (.*);
endmodule

module design1_wrapper #(
    parameter int unsigned DDR_RST_CYCLES = 10,
    parameter int unsigned DDR_CKE_CYCLES = 5,
    parameter int unsigned MEM_WORDS      = 1024
) (
    inout wire [14:0] DDR_addr,
    inout wire [2:0]  DDR_ba,
    inout wire        DDR_cas_n,
    inout wire        DDR_ck_n,
    inout wire        DDR_ck_p,
    inout wire        DDR_cke,
    inout wire        DDR_cs_n,
    inout wire [3:0]  DDR_dm,
    inout wire [31:0] DDR_dq,
    inout wire [3:0]  DDR_dqs_n,
    inout wire [3:0]  DDR_dqs_p,
    inout wire        DDR_odt,
    inout wire        DDR_ras_n,
    inout wire        DDR_reset_n,
    inout wire        DDR_we_n,
    inout wire        FIXED_IO_ddr_vrn,
    inout wire        FIXED_IO_ddr_vrp,
    inout wire [53:0] FIXED_IO_mio,
    inout wire        FIXED_IO_ps_clk,
    inout wire        FIXED_IO_ps_porb,
    inout wire        FIXED_IO_ps_srstb
);
    logic pl_resetn0;

    design_1 #(
        .DDR_RST_CYCLES(DDR_RST_CYCLES),
        .DDR_CKE_CYCLES(DDR_CKE_CYCLES),
        .MEM_WORDS     (MEM_WORDS)
    ) design_1_i (
        .ps_clk     (FIXED_IO_ps_clk),
        .ps_porb    (FIXED_IO_ps_porb),
        .ps_srstb   (FIXED_IO_ps_srstb),
        .ddr_addr   (DDR_addr),
        .ddr_ba     (DDR_ba),
        .ddr_cas_n  (DDR_cas_n),
        .ddr_ras_n  (DDR_ras_n),
        .ddr_we_n   (DDR_we_n),
        .ddr_ck_p   (DDR_ck_p),
        .ddr_ck_n   (DDR_ck_n),
        .ddr_cke    (DDR_cke),
        .ddr_cs_n   (DDR_cs_n),
        .ddr_odt    (DDR_odt),
        .ddr_reset_n(DDR_reset_n),
        .ddr_dm     (DDR_dm),
        .pl_resetn0 (pl_resetn0)
    );

    // Data path and unused MIO are never driven by the model; only PL reset goes out on MIO[7]
    assign DDR_dq           = {32{1'bz}};
    assign DDR_dqs_p        = {4{1'bz}};
    assign DDR_dqs_n        = {4{1'bz}};
    assign FIXED_IO_ddr_vrn = 1'bz;
    assign FIXED_IO_ddr_vrp = 1'bz;
    assign FIXED_IO_mio     = {{46{1'bz}}, pl_resetn0, {7{1'bz}}};
endmodule

// File: tb/tb_design1_wrapper.sv
// Self-checking bench for design1_wrapper: DDR power-up timing, soft PL reset and DDR memory tasks.

module tb_design1_wrapper;
    logic clk_r   = 1'b0;
    logic porb_r  = 1'b0;
    logic srstb_r = 1'b0;

    wire        ps_clk, ps_porb, ps_srstb;
    wire [14:0] DDR_addr;
    wire [2:0]  DDR_ba;
    wire        DDR_cas_n, DDR_ck_n, DDR_ck_p, DDR_cke, DDR_cs_n;
    wire [3:0]  DDR_dm, DDR_dqs_n, DDR_dqs_p;
    wire [31:0] DDR_dq;
    wire        DDR_odt, DDR_ras_n, DDR_reset_n, DDR_we_n;
    wire        vrn, vrp;
    wire [53:0] mio;

    assign ps_clk   = clk_r;
    assign ps_porb  = porb_r;
    assign ps_srstb = srstb_r;

    design1_wrapper dut (
        .DDR_addr(DDR_addr), .DDR_ba(DDR_ba), .DDR_cas_n(DDR_cas_n), .DDR_ck_n(DDR_ck_n),
        .DDR_ck_p(DDR_ck_p), .DDR_cke(DDR_cke), .DDR_cs_n(DDR_cs_n), .DDR_dm(DDR_dm),
        .DDR_dq(DDR_dq), .DDR_dqs_n(DDR_dqs_n), .DDR_dqs_p(DDR_dqs_p), .DDR_odt(DDR_odt),
        .DDR_ras_n(DDR_ras_n), .DDR_reset_n(DDR_reset_n), .DDR_we_n(DDR_we_n),
        .FIXED_IO_ddr_vrn(vrn), .FIXED_IO_ddr_vrp(vrp), .FIXED_IO_mio(mio),
        .FIXED_IO_ps_clk(ps_clk), .FIXED_IO_ps_porb(ps_porb), .FIXED_IO_ps_srstb(ps_srstb)
    );

    always #5 clk_r = ~clk_r;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pin behaviour is a function of edges seen since reset release
    logic       tb_rst_n;
    int         edges = 0;
    logic [3:0] ctrl_model = 4'h0;
    bit         mon_en = 1'b1;

    assign tb_rst_n = porb_r & srstb_r;

    always @(posedge clk_r or negedge tb_rst_n) begin
        if (!tb_rst_n) edges <= 0;
        else           edges <= edges + 1;
    end

    always @(negedge clk_r) begin
        logic exp_ck;
        if (mon_en) begin
            exp_ck = (edges > 15) ? 1'((edges - 15) % 2) : 1'b0;
            check("ddr_reset_n", 32'(DDR_reset_n), 32'(edges >= 10));
            check("ddr_cke", 32'(DDR_cke), 32'(edges >= 15));
            check("ddr_ck_p", 32'(DDR_ck_p), 32'(exp_ck));
            check("ddr_ck_n", 32'(DDR_ck_n), 32'(!exp_ck));
            check("ddr_cmd_nop", 32'({DDR_cs_n, DDR_ras_n, DDR_cas_n, DDR_we_n}), 32'hF);
            check("ddr_addr_ba_dm_odt", 32'({DDR_addr, DDR_ba, DDR_dm, DDR_odt}), 32'h0);
            check("pl_resetn0", 32'(mio[7]), 32'(tb_rst_n & ~ctrl_model[0]));
        end
    end

    // Short reset pulse inside the low clock phase, with immediate async checks
    task automatic pulse_reset(input bit use_porb, input int offs);
        @(negedge clk_r);
        #(offs);
        if (use_porb) porb_r = 1'b0;
        else          srstb_r = 1'b0;
        #1;
        check("async_ddr_reset_n", 32'(DDR_reset_n), 32'h0);
        check("async_ddr_cke", 32'(DDR_cke), 32'h0);
        check("async_mio7", 32'(mio[7]), 32'h0);
        ctrl_model = 4'h0;
        porb_r  = 1'b1;
        srstb_r = 1'b1;
    endtask

    task automatic measure_seq(input string tag);
        int first_rst = 0;
        int first_cke = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_r);
            if (first_rst == 0 && DDR_reset_n === 1'b1) first_rst = k;
            if (first_cke == 0 && DDR_cke === 1'b1)     first_cke = k;
        end
        check({tag, "_reset_n_rise_edge"}, 32'(first_rst), 32'd10);
        check({tag, "_cke_rise_edge"}, 32'(first_cke), 32'd15);
    endtask

    typedef struct {
        logic [31:0] v;
        logic        exp_mio7;
        logic [3:0]  exp_ctrl;
    } soft_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    soft_vec_t   soft_tab [7];
    rd_vec_t     rd_tab [6];
    logic [31:0] ref_mem [1024];
    bit          ref_ok [1024];

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] v;
        logic [1:0]  mode;
        int          n;
        int          w;

        soft_tab[0] = '{32'h0000_0001, 1'b0, 4'h1};
        soft_tab[1] = '{32'h0000_0000, 1'b1, 4'h0};
        soft_tab[2] = '{32'hFFFF_FFF0, 1'b1, 4'h0};
        soft_tab[3] = '{32'h0000_0003, 1'b0, 4'h3};
        soft_tab[4] = '{32'hABCD_0012, 1'b1, 4'h2};
        soft_tab[5] = '{32'h0000_000F, 1'b0, 4'hF};
        soft_tab[6] = '{32'h0000_0000, 1'b1, 4'h0};

        rd_tab[0] = '{32'h0000_0FF8, 32'd0};
        rd_tab[1] = '{32'h0000_0FFC, 32'd1};
        rd_tab[2] = '{32'h0000_0000, 32'd2};
        rd_tab[3] = '{32'h0000_0004, 32'd3};
        rd_tab[4] = '{32'h0000_1000, 32'd2};
        rd_tab[5] = '{32'h0000_0FFB, 32'd0};

        repeat (3) @(negedge clk_r);
        check("reset_fpga_rst_ctrl", 32'(dut.design_1_i.processing_system7_0.inst.fpga_rst_ctrl), 32'h0);
        porb_r  = 1'b1;
        srstb_r = 1'b1;
        measure_seq("por");

        for (int i = 0; i < 7; i++) begin
            @(negedge clk_r);
            dut.design_1_i.processing_system7_0.inst.fpga_soft_reset(soft_tab[i].v);
            ctrl_model = soft_tab[i].v[3:0];
            @(negedge clk_r);
            check("soft_mio7", 32'(mio[7]), 32'(soft_tab[i].exp_mio7));
            check("soft_ctrl", 32'(dut.design_1_i.processing_system7_0.inst.fpga_rst_ctrl), 32'(soft_tab[i].exp_ctrl));
            check("soft_cke_held", 32'(DDR_cke), 32'h1);
        end

        // Restart, then interrupt the sequence in the middle of CKE_WAIT
        pulse_reset(1'b0, 2);
        repeat (12) @(negedge clk_r);
        check("mid_cke_wait_state", 32'({DDR_reset_n, DDR_cke}), 32'h2);
        pulse_reset(1'b0, 1);
        measure_seq("srst");

        dut.design_1_i.processing_system7_0.inst.pre_load_mem(2'b10, 32'h0000_0FF8, 4);
        for (int j = 0; j < 4; j++) begin
            ref_mem[(1022 + j) % 1024] = 32'(j);
            ref_ok[(1022 + j) % 1024]  = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            dut.design_1_i.processing_system7_0.inst.read_mem(rd_tab[i].addr, rd);
            check("mem_incr_wrap", rd, rd_tab[i].exp);
        end

        dut.design_1_i.processing_system7_0.inst.pre_load_mem(2'b11, 32'h0, 1);
        ref_mem[0] = 32'hFFFF_FFFF;
        pulse_reset(1'b1, 2);
        dut.design_1_i.processing_system7_0.inst.read_mem(32'h0, rd);
        check("mem_survives_porb", rd, 32'hFFFF_FFFF);

        // Random preloads, reads, soft resets and reset pulses against the model
        for (int t = 0; t < 30; t++) begin
            mode = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 16383));
            n    = int'($urandom_range(1, 12));
            dut.design_1_i.processing_system7_0.inst.pre_load_mem(mode, addr, n);
            for (int j = 0; j < n; j++) begin
                w = int'(((addr >> 2) + 32'(j)) % 1024);
                ref_ok[w] = (mode != 2'b00);
                case (mode)
                    2'b01:   ref_mem[w] = 32'h0;
                    2'b10:   ref_mem[w] = 32'(j);
                    2'b11:   ref_mem[w] = 32'hFFFF_FFFF;
                    default: ref_mem[w] = 32'h0;
                endcase
            end
            for (int r = 0; r < 3; r++) begin
                int j;
                j = int'($urandom_range(0, n - 1));
                w = int'(((addr >> 2) + 32'(j)) % 1024);
                if (ref_ok[w]) begin
                    dut.design_1_i.processing_system7_0.inst.read_mem(addr + 32'(4 * j), rd);
                    check("rand_mem_fill", rd, ref_mem[w]);
                end
                w = int'($urandom_range(0, 1023));
                if (ref_ok[w]) begin
                    dut.design_1_i.processing_system7_0.inst.read_mem(32'(w * 4 + 4096), rd);
                    check("rand_mem_keep", rd, ref_mem[w]);
                end
            end
            @(negedge clk_r);
            v = $urandom;
            dut.design_1_i.processing_system7_0.inst.fpga_soft_reset(v);
            ctrl_model = v[3:0];
            if ($urandom_range(0, 3) == 0) pulse_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            repeat ($urandom_range(1, 20)) @(negedge clk_r);
        end

        repeat (20) @(negedge clk_r);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
